// File: rtl/axis_multi_fifo_pkg.sv
// Shared sizing helpers and entry layout for the AXI4-Stream FIFO bank.
// An entry is packed as {tlast, tkeep, tdata}, with tdata in the low bits.
package axis_multi_fifo_pkg;

    // Ceiling log2; returns 0 for values of 0 or 1.
    function automatic int clog2(input int value);
        int result;
        result = 0;
        while ((1 << result) < value) begin
            result++;
        end
        return result;
    endfunction

    // Pointer width: one extra MSB separates full from empty.
    function automatic int ptr_width(input int depth);
        return clog2(depth) + 1;
    endfunction

    // Width of one stored beat: tdata + tkeep + tlast.
    function automatic int entry_width(input int dwidth);
        return dwidth + dwidth / 8 + 1;
    endfunction

    // Bit offsets of each field inside an entry.
    function automatic int tdata_lsb(input int dwidth);
        return 0;
    endfunction

    function automatic int tkeep_lsb(input int dwidth);
        return dwidth;
    endfunction

    function automatic int tlast_bit(input int dwidth);
        return dwidth + dwidth / 8;
    endfunction

    // Default-configuration constants for status/host logic that sizes its
    // own buses from the standard kernel configuration.
    localparam int DEF_DWIDTH = 64;
    localparam int DEF_DEPTH  = 16;
    localparam int PTR_W      = ptr_width(DEF_DEPTH);
    localparam int ENT_W      = entry_width(DEF_DWIDTH);

endpackage

// File: rtl/axis_fifo_ch.sv
// Single-channel FWFT AXI4-Stream FIFO with optional store-and-forward mode.
// In packet mode a deadlock guard streams an oversize packet through once the
// buffer is full without holding a complete packet.
module axis_fifo_ch
    import axis_multi_fifo_pkg::*;
#(
    parameter int   DWIDTH    = 64,
    parameter int   DEPTH     = 16,
    parameter bit   PKT_MODE  = 1'b0,
    parameter int   AF_THRESH = DEPTH - 2,
    localparam int  CH_PTR_W  = ptr_width(DEPTH)
) (
    input  logic                  ap_clk,
    input  logic                  ap_rst_n,
    input  logic                  s_tvalid,
    output logic                  s_tready,
    input  logic [DWIDTH-1:0]     s_tdata,
    input  logic [DWIDTH/8-1:0]   s_tkeep,
    input  logic                  s_tlast,
    output logic                  m_tvalid,
    input  logic                  m_tready,
    output logic [DWIDTH-1:0]     m_tdata,
    output logic [DWIDTH/8-1:0]   m_tkeep,
    output logic                  m_tlast,
    output logic [CH_PTR_W-1:0]   count,
    output logic                  almost_full,
    output logic [CH_PTR_W-1:0]   pkt_count
);

    localparam int CH_ENT_W = entry_width(DWIDTH);
    localparam int ADDR_W   = CH_PTR_W - 1;
    localparam int DATA_LSB = tdata_lsb(DWIDTH);
    localparam int KEEP_LSB = tkeep_lsb(DWIDTH);
    localparam int LAST_BIT = tlast_bit(DWIDTH);
    localparam logic [CH_PTR_W-1:0] DEPTH_V = CH_PTR_W'(DEPTH);
    localparam logic [CH_PTR_W-1:0] AF_V    = CH_PTR_W'(AF_THRESH);

    logic [CH_ENT_W-1:0] mem [DEPTH];
    logic [CH_ENT_W-1:0] head;
    logic [CH_PTR_W-1:0] wr_ptr, rd_ptr;
    logic [CH_PTR_W-1:0] count_q, count_d;
    logic [CH_PTR_W-1:0] pkt_q, pkt_d;
    logic                ready_q;
    logic                cut_q, cut_d;
    logic                cut_through;
    logic                wr_en, rd_en;

    assign wr_en = s_tvalid & ready_q;
    assign rd_en = m_tvalid & m_tready;

    // FWFT: the head entry is always presented without a read request.
    assign head    = mem[rd_ptr[ADDR_W-1:0]];
    assign m_tdata = head[DATA_LSB +: DWIDTH];
    assign m_tkeep = head[KEEP_LSB +: DWIDTH/8];
    assign m_tlast = head[LAST_BIT];

    // Full buffer with no complete packet inside would never drain otherwise.
    assign cut_through = cut_q | ((count_q == DEPTH_V) && (pkt_q == '0));

    assign m_tvalid    = PKT_MODE ? ((pkt_q != '0) | (cut_through & (count_q != '0)))
                                  : (count_q != '0);
    assign s_tready    = ready_q;
    assign count       = count_q;
    assign pkt_count   = pkt_q;
    assign almost_full = (count_q >= AF_V);

    // Next occupancy, packet count and cut-through state from this cycle's handshakes.
    always_comb begin
        // NOTE: every output of this block is given a default first so that no
        // path leaves a variable unassigned and no latch is inferred.
        count_d = count_q;
        pkt_d   = pkt_q;
        cut_d   = cut_q;
        case ({wr_en, rd_en})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
        case ({wr_en & s_tlast, rd_en & m_tlast})
            2'b10:   pkt_d = pkt_q + 1'b1;
            2'b01:   pkt_d = pkt_q - 1'b1;
            default: pkt_d = pkt_q;
        endcase
        if (rd_en && m_tlast) begin
            cut_d = 1'b0;
        end else if ((count_q == DEPTH_V) && (pkt_q == '0)) begin
            cut_d = 1'b1;
        end
    end

    // Control state: pointers, counters, registered ready and cut-through flag.
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        // NOTE: state is updated with non-blocking assignments so every register
        // samples the pre-edge values, independent of statement order.
        if (!ap_rst_n) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
            pkt_q   <= '0;
            cut_q   <= 1'b0;
            ready_q <= 1'b0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + 1'b1;
            if (rd_en) rd_ptr <= rd_ptr + 1'b1;
            count_q <= count_d;
            pkt_q   <= pkt_d;
            cut_q   <= cut_d;
            ready_q <= (count_d < DEPTH_V);
        end
    end

    // Beat storage written on an accepted input beat.
    always_ff @(posedge ap_clk) begin
        // NOTE: the storage array has no reset; reset clears the pointers, so
        // stale entries are never presented and the array can map onto RAM.
        if (wr_en) begin
            mem[wr_ptr[ADDR_W-1:0]] <= {s_tlast, s_tkeep, s_tdata};
        end
    end

endmodule

// File: rtl/axis_multi_fifo.sv
// N-channel AXI4-Stream FIFO bank: independent per-channel FWFT queues on
// flattened buses, each optionally in store-and-forward packet mode.
module axis_multi_fifo
    import axis_multi_fifo_pkg::*;
#(
    parameter int                NUM_CH    = 2,
    parameter int                DWIDTH    = 64,
    parameter int                DEPTH     = 16,
    parameter logic [NUM_CH-1:0] PKT_MODE  = '0,
    parameter int                AF_THRESH = DEPTH - 2,
    localparam int               TOP_PTR_W = ptr_width(DEPTH)
) (
    input  logic                          ap_clk,
    input  logic                          ap_rst_n,
    input  logic [NUM_CH-1:0]             s_tvalid,
    output logic [NUM_CH-1:0]             s_tready,
    input  logic [NUM_CH*DWIDTH-1:0]      s_tdata,
    input  logic [NUM_CH*DWIDTH/8-1:0]    s_tkeep,
    input  logic [NUM_CH-1:0]             s_tlast,
    output logic [NUM_CH-1:0]             m_tvalid,
    input  logic [NUM_CH-1:0]             m_tready,
    output logic [NUM_CH*DWIDTH-1:0]      m_tdata,
    output logic [NUM_CH*DWIDTH/8-1:0]    m_tkeep,
    output logic [NUM_CH-1:0]             m_tlast,
    output logic [NUM_CH*TOP_PTR_W-1:0]   count,
    output logic [NUM_CH-1:0]             almost_full,
    output logic [NUM_CH*TOP_PTR_W-1:0]   pkt_count
);

    localparam int KW = DWIDTH / 8;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        axis_fifo_ch #(
            .DWIDTH    (DWIDTH),
            .DEPTH     (DEPTH),
            .PKT_MODE  (PKT_MODE[i]),
            .AF_THRESH (AF_THRESH)
        ) u_ch (
            .ap_clk      (ap_clk),
            .ap_rst_n    (ap_rst_n),
            .s_tvalid    (s_tvalid[i]),
            .s_tready    (s_tready[i]),
            .s_tdata     (s_tdata[i*DWIDTH +: DWIDTH]),
            .s_tkeep     (s_tkeep[i*KW +: KW]),
            .s_tlast     (s_tlast[i]),
            .m_tvalid    (m_tvalid[i]),
            .m_tready    (m_tready[i]),
            .m_tdata     (m_tdata[i*DWIDTH +: DWIDTH]),
            .m_tkeep     (m_tkeep[i*KW +: KW]),
            .m_tlast     (m_tlast[i]),
            .count       (count[i*TOP_PTR_W +: TOP_PTR_W]),
            .almost_full (almost_full[i]),
            .pkt_count   (pkt_count[i*TOP_PTR_W +: TOP_PTR_W])
        );
    end

endmodule

// File: tb/tb_axis_multi_fifo.sv
// Directed bench for axis_multi_fifo: ch0 stream mode, ch1 packet mode,
// DEPTH=16, DWIDTH=64. Table-driven stream checks plus hand-written sequences.
module tb_axis_multi_fifo;

    localparam int NCH = 2;
    localparam int DW  = 64;
    localparam int KW  = 8;
    localparam int DEP = 16;
    localparam int PW  = 5;

    logic                ap_clk = 1'b0;
    logic                ap_rst_n;
    logic [NCH-1:0]      s_tvalid, s_tready, s_tlast;
    logic [NCH*DW-1:0]   s_tdata;
    logic [NCH*KW-1:0]   s_tkeep;
    logic [NCH-1:0]      m_tvalid, m_tready, m_tlast;
    logic [NCH*DW-1:0]   m_tdata;
    logic [NCH*KW-1:0]   m_tkeep;
    logic [NCH*PW-1:0]   count, pkt_count;
    logic [NCH-1:0]      almost_full;

    axis_multi_fifo #(
        .NUM_CH(NCH), .DWIDTH(DW), .DEPTH(DEP), .PKT_MODE(2'b10), .AF_THRESH(14)
    ) dut (
        .ap_clk(ap_clk), .ap_rst_n(ap_rst_n),
        .s_tvalid(s_tvalid), .s_tready(s_tready), .s_tdata(s_tdata),
        .s_tkeep(s_tkeep), .s_tlast(s_tlast),
        .m_tvalid(m_tvalid), .m_tready(m_tready), .m_tdata(m_tdata),
        .m_tkeep(m_tkeep), .m_tlast(m_tlast),
        .count(count), .almost_full(almost_full), .pkt_count(pkt_count)
    );

    always #5 ap_clk = ~ap_clk;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic        vld;
        logic [63:0] data;
        logic [7:0]  keep;
        logic        last;
        logic        rdy;
        logic        e_mvld;
        logic [63:0] e_data;
        logic [7:0]  e_keep;
        logic        e_last;
        logic        e_srdy;
        logic [4:0]  e_cnt;
        logic        e_af;
    } vec_t;

    vec_t        vecs[$];
    logic [63:0] sb[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge ap_clk);
        #1;
    endtask

    task automatic drive(input int ch, input logic v, input logic [63:0] d,
                         input logic [7:0] k, input logic l);
        s_tvalid[ch]         = v;
        s_tdata[ch*DW +: DW] = d;
        s_tkeep[ch*KW +: KW] = k;
        s_tlast[ch]          = l;
    endtask

    function automatic logic [4:0] cnt_of(input int ch);
        return count[ch*PW +: PW];
    endfunction

    function automatic logic [4:0] pkt_of(input int ch);
        return pkt_count[ch*PW +: PW];
    endfunction

    function automatic logic [63:0] dat_of(input int ch);
        return m_tdata[ch*DW +: DW];
    endfunction

    function automatic vec_t mk(input logic vld, input logic [63:0] data, input logic [7:0] keep,
                                input logic last, input logic rdy, input logic e_mvld,
                                input logic [63:0] e_data, input logic [7:0] e_keep,
                                input logic e_last, input logic e_srdy, input int e_cnt,
                                input logic e_af);
        vec_t v;
        v.vld = vld; v.data = data; v.keep = keep; v.last = last; v.rdy = rdy;
        v.e_mvld = e_mvld; v.e_data = e_data; v.e_keep = e_keep; v.e_last = e_last;
        v.e_srdy = e_srdy; v.e_cnt = 5'(e_cnt); v.e_af = e_af;
        return v;
    endfunction

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin : main
        int next_wr;
        int rd_idx;
        bit seen_valid;

        // Stream-mode table for ch0: single beat, then fill to full and drain.
        vecs.push_back(mk(1, 64'hA5, 8'hFF, 1, 0,  0, 0, 0, 0,        1, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0,           1, 64'hA5, 8'hFF, 1, 1, 1, 0));
        vecs.push_back(mk(0, 0, 0, 0, 1,           1, 64'hA5, 8'hFF, 1, 1, 1, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0,           0, 0, 0, 0,        1, 0, 0));
        for (int i = 0; i < 16; i++)
            vecs.push_back(mk(1, 64'h100 + i, 8'(i), i == 15, 0,
                              i > 0, 64'h100, 8'h00, 0, 1, i, i >= 14));
        vecs.push_back(mk(0, 0, 0, 0, 0,           1, 64'h100, 8'h00, 0, 0, 16, 1));
        for (int j = 0; j < 16; j++)
            vecs.push_back(mk(0, 0, 0, 0, 1,
                              1, 64'h100 + j, 8'(j), j == 15, j != 0, 16 - j, (16 - j) >= 14));
        vecs.push_back(mk(0, 0, 0, 0, 0,           0, 0, 0, 0,        1, 0, 0));

        // Reset state.
        ap_rst_n = 1'b0;
        s_tvalid = '0; s_tdata = '0; s_tkeep = '0; s_tlast = '0; m_tready = '0;
        #2;
        check("reset s_tready", 64'(s_tready), 64'h0);
        check("reset m_tvalid", 64'(m_tvalid), 64'h0);
        check("reset count", 64'(count), 64'h0);
        check("reset almost_full", 64'(almost_full), 64'h0);
        #21 ap_rst_n = 1'b1;
        #1;
        check("s_tready before first edge", 64'(s_tready), 64'h0);
        step();

        // Apply the table.
        foreach (vecs[i]) begin
            drive(0, vecs[i].vld, vecs[i].data, vecs[i].keep, vecs[i].last);
            m_tready[0] = vecs[i].rdy;
            #1;
            check($sformatf("vec%0d m_tvalid0", i), 64'(m_tvalid[0]), 64'(vecs[i].e_mvld));
            if (vecs[i].e_mvld) begin
                check($sformatf("vec%0d m_tdata0", i), dat_of(0), vecs[i].e_data);
                check($sformatf("vec%0d m_tkeep0", i), 64'(m_tkeep[7:0]), 64'(vecs[i].e_keep));
                check($sformatf("vec%0d m_tlast0", i), 64'(m_tlast[0]), 64'(vecs[i].e_last));
            end
            check($sformatf("vec%0d s_tready0", i), 64'(s_tready[0]), 64'(vecs[i].e_srdy));
            check($sformatf("vec%0d count0", i), 64'(cnt_of(0)), 64'(vecs[i].e_cnt));
            check($sformatf("vec%0d almost_full0", i), 64'(almost_full[0]), 64'(vecs[i].e_af));
            check($sformatf("vec%0d m_tvalid1 idle", i), 64'(m_tvalid[1]), 64'h0);
            step();
        end
        drive(0, 0, 0, 0, 0);
        m_tready = '0;

        // Full with simultaneous read and write on ch0.
        sb.delete();
        for (int i = 0; i < 16; i++) begin
            drive(0, 1, 64'h200 + i, 8'hFF, 0);
            sb.push_back(64'h200 + i);
            step();
        end
        drive(0, 0, 0, 0, 0);
        next_wr = 16;
        for (int k = 0; k < 80; k++) begin
            drive(0, next_wr < 26, 64'h200 + next_wr, 8'hFF, 0);
            m_tready[0] = 1'b1;
            #1;
            if (k == 0) begin
                check("full s_tready0", 64'(s_tready[0]), 64'h0);
                check("full count0", 64'(cnt_of(0)), 64'd16);
            end else if (next_wr < 26) begin
                check($sformatf("steady%0d count0", k), 64'(cnt_of(0)), 64'd15);
                check($sformatf("steady%0d s_tready0", k), 64'(s_tready[0]), 64'h1);
            end
            if (m_tvalid[0]) begin
                if (sb.size() == 0) check("full rw spurious beat", 64'h1, 64'h0);
                else check($sformatf("full rw data k%0d", k), dat_of(0), sb.pop_front());
            end
            if (s_tvalid[0] && s_tready[0]) begin
                sb.push_back(64'h200 + next_wr);
                next_wr++;
            end
            step();
            if (next_wr == 26 && sb.size() == 0) break;
        end
        drive(0, 0, 0, 0, 0);
        m_tready = '0;
        check("full rw beats left", 64'(sb.size()), 64'h0);
        check("full rw written", 64'(next_wr), 64'd26);
        check("full rw final count0", 64'(cnt_of(0)), 64'h0);

        // Packet mode on ch1: 4-beat packet with a gap before tlast.
        for (int c = 0; c < 5; c++) begin
            if (c == 3) drive(1, 0, 0, 0, 0);
            else        drive(1, 1, 64'h300 + (c > 3 ? 3 : c), 8'hFF, c == 4);
            #1;
            check($sformatf("pkt hold c%0d m_tvalid1", c), 64'(m_tvalid[1]), 64'h0);
            check($sformatf("pkt hold c%0d pkt_count1", c), 64'(pkt_of(1)), 64'h0);
            step();
        end
        drive(1, 0, 0, 0, 0);
        check("pkt ready m_tvalid1", 64'(m_tvalid[1]), 64'h1);
        check("pkt ready pkt_count1", 64'(pkt_of(1)), 64'h1);
        check("pkt ready count1", 64'(cnt_of(1)), 64'd4);
        m_tready[1] = 1'b1;
        for (int j = 0; j < 4; j++) begin
            #1;
            check($sformatf("pkt beat%0d valid", j), 64'(m_tvalid[1]), 64'h1);
            check($sformatf("pkt beat%0d data", j), dat_of(1), 64'h300 + j);
            check($sformatf("pkt beat%0d last", j), 64'(m_tlast[1]), 64'(j == 3));
            step();
        end
        check("pkt done m_tvalid1", 64'(m_tvalid[1]), 64'h0);
        check("pkt done pkt_count1", 64'(pkt_of(1)), 64'h0);

        // Oversize 20-beat packet on ch1 forces cut-through.
        next_wr = 0; rd_idx = 0; seen_valid = 0;
        for (int k = 0; k < 200; k++) begin
            drive(1, next_wr < 20, 64'h400 + next_wr, 8'hF0, next_wr == 19);
            m_tready[1] = 1'b1;
            #1;
            if (m_tvalid[1]) begin
                if (!seen_valid) begin
                    check("cut first valid count1", 64'(cnt_of(1)), 64'd16);
                    check("cut first valid pkt_count1", 64'(pkt_of(1)), 64'h0);
                    seen_valid = 1;
                end
                check($sformatf("cut beat%0d data", rd_idx), dat_of(1), 64'h400 + rd_idx);
                check($sformatf("cut beat%0d last", rd_idx), 64'(m_tlast[1]), 64'(rd_idx == 19));
                rd_idx++;
            end
            if (s_tvalid[1] && s_tready[1]) next_wr++;
            step();
            if (rd_idx == 20) break;
        end
        drive(1, 0, 0, 0, 0);
        check("cut beats delivered", 64'(rd_idx), 64'd20);
        check("cut done pkt_count1", 64'(pkt_of(1)), 64'h0);

        // Next packet is store-and-forward again.
        drive(1, 1, 64'h500, 8'hFF, 0);
        #1 check("after cut b0 m_tvalid1", 64'(m_tvalid[1]), 64'h0);
        step();
        drive(1, 1, 64'h501, 8'hFF, 1);
        #1 check("after cut b1 m_tvalid1", 64'(m_tvalid[1]), 64'h0);
        step();
        drive(1, 0, 0, 0, 0);
        check("after cut valid", 64'(m_tvalid[1]), 64'h1);
        check("after cut data0", dat_of(1), 64'h500);
        step();
        check("after cut data1", dat_of(1), 64'h501);
        check("after cut last1", 64'(m_tlast[1]), 64'h1);
        step();
        check("after cut empty", 64'(m_tvalid[1]), 64'h0);
        m_tready = '0;

        // Asynchronous reset mid-packet on both channels.
        for (int i = 0; i < 3; i++) begin
            drive(0, 1, 64'h600 + i, 8'hFF, 0);
            drive(1, i < 2, 64'h700 + i, 8'hFF, 0);
            step();
        end
        drive(0, 0, 0, 0, 0);
        drive(1, 0, 0, 0, 0);
        check("pre-reset m_tvalid0", 64'(m_tvalid[0]), 64'h1);
        #2 ap_rst_n = 1'b0;
        #1;
        check("async reset m_tvalid", 64'(m_tvalid), 64'h0);
        check("async reset s_tready", 64'(s_tready), 64'h0);
        check("async reset count0", 64'(cnt_of(0)), 64'h0);
        check("async reset count1", 64'(cnt_of(1)), 64'h0);
        check("async reset almost_full", 64'(almost_full), 64'h0);
        #3 ap_rst_n = 1'b1;
        step();
        check("post reset s_tready", 64'(s_tready), 64'h3);
        drive(0, 1, 64'h777, 8'h0F, 0);
        drive(1, 1, 64'h888, 8'h3C, 1);
        step();
        drive(0, 0, 0, 0, 0);
        drive(1, 0, 0, 0, 0);
        check("post reset m_tvalid", 64'(m_tvalid), 64'h3);
        check("post reset data0", dat_of(0), 64'h777);
        check("post reset keep0", 64'(m_tkeep[7:0]), 64'h0F);
        check("post reset data1", dat_of(1), 64'h888);
        check("post reset count0", 64'(cnt_of(0)), 64'h1);
        check("post reset pkt_count1", 64'(pkt_of(1)), 64'h1);
        m_tready = 2'b11;
        step();
        m_tready = '0;
        check("post reset drained", 64'(m_tvalid), 64'h0);
        check("post reset count1", 64'(cnt_of(1)), 64'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/axis_multi_fifo.md
Name: axis_multi_fifo

Overview:
- Parametrised N-channel AXI4-Stream FIFO bank for kernel datapaths; next generation of the fixed dual-queue kernel core.
- Each channel is an independent first-word-fall-through (FWFT) queue. It carries tdata, tkeep and tlast end-to-end; tkeep and tlast are no longer tied off.
- Optional per-channel packet (store-and-forward) mode, per-channel fill level and almost-full flags for host/status logic.

Parameters:
- NUM_CH, 2, number of independent channels (1..16).
- DWIDTH, 64, tdata width per channel in bits; multiple of 8.
- DEPTH, 16, entries per channel; power of two, >= 2.
- PKT_MODE, 0, per-channel bit mask [NUM_CH-1:0]; bit set = store-and-forward on that channel.
- AF_THRESH, DEPTH-2, almost_full asserts when count >= AF_THRESH.

Ports:
- ap_clk  in  1  kernel clock
- ap_rst_n  in  1  asynchronous active-low reset
- s_tvalid  in  NUM_CH  per-channel input valid
- s_tready  out  NUM_CH  per-channel input ready
- s_tdata  in  NUM_CH*DWIDTH  input data, channel i at [i*DWIDTH +: DWIDTH]
- s_tkeep  in  NUM_CH*DWIDTH/8  input byte keep
- s_tlast  in  NUM_CH  input end-of-packet
- m_tvalid  out  NUM_CH  output valid
- m_tready  in  NUM_CH  output ready
- m_tdata  out  NUM_CH*DWIDTH  output data
- m_tkeep  out  NUM_CH*DWIDTH/8  output keep
- m_tlast  out  NUM_CH  output end-of-packet
- count  out  NUM_CH*(clog2(DEPTH)+1)  per-channel occupancy
- almost_full  out  NUM_CH  count >= AF_THRESH
- pkt_count  out  NUM_CH*(clog2(DEPTH)+1)  complete packets stored per channel

Behaviour:
- Reset: ap_rst_n low asynchronously clears pointers, count and pkt_count, and forces s_tready=0, m_tvalid=0, almost_full=0 immediately.
  - m_tdata, m_tkeep and m_tlast are don't-care while m_tvalid=0.
  - s_tready rises on the first clock edge after deassertion.
  - Reset mid-packet discards all contents; no partial packet survives.
- Storage: one entry per beat, holding {tlast, tkeep, tdata}, width DWIDTH + DWIDTH/8 + 1. Circular buffer with clog2(DEPTH)+1-bit read and write pointers; the MSB distinguishes full from empty. Pointers wrap modulo DEPTH.
- Write: a beat is accepted when s_tvalid & s_tready. s_tready = (count < DEPTH), registered. When full, no write is accepted even if a read occurs in the same cycle; ready reasserts the cycle after count drops.
- Read: a beat is consumed when m_tvalid & m_tready. Output is FWFT: data is presented from the head entry without a read request.
- Latency: a beat written into an empty channel gives m_tvalid=1 on the next cycle (1-cycle write-to-output). Throughput is one beat per cycle per channel with both sides ready.
- Simultaneous read and write:
  - count is unchanged; both pointers advance.
  - On an empty channel, a write cannot be read in the same cycle; no bypass.
- count updates 1 cycle after the handshake. almost_full is combinational from count.
- Stream mode (PKT_MODE bit 0): m_tvalid = (count != 0).
- Packet mode (PKT_MODE bit 1):
  - m_tvalid = (pkt_count != 0) | cut_through.
  - pkt_count increments on an accepted beat with s_tlast=1 and decrements on a consumed beat with m_tlast=1. Both in the same cycle leaves it unchanged.
  - Deadlock guard: if count == DEPTH and pkt_count == 0, set cut_through. The channel then streams the oversize packet's beats as in stream mode. cut_through clears on consumption of the beat carrying tlast.
- Channels share nothing but clock and reset; no cross-channel ordering or arbitration.
- tkeep and tlast pass through unmodified; tkeep=0 beats are stored like any other beat.

Decomposition:
- Shared package/header holds:
  - clog2 constant function
  - localparams PTR_W = clog2(DEPTH)+1 and ENT_W = DWIDTH + DWIDTH/8 + 1
  - field offsets of tlast, tkeep and tdata inside an entry
- Sub-module axis_fifo_ch: a single-channel FIFO with a PKT_MODE scalar parameter, instantiated NUM_CH times by generate. The top only slices the flattened buses.

Test Plan:
- Single beat: NUM_CH=2, DEPTH=16. Ch0 writes 0xA5 (keep 0xFF, last 1) at cycle t -> m_tvalid[0]=1 at t+1 with 0xA5/0xFF/1; ch1 stays idle.
- Fill/drain: write 16 beats with m_tready=0 -> s_tready=0 after the 16th, count=16, almost_full from count=14. Then drain with m_tready=1 -> data in order 0..15, s_tready=1 one cycle after the first read.
- Full plus simultaneous read/write: at count=16 hold s_tvalid=1 and m_tready=1 -> the first cycle reads only (no write). Steady state then alternates to one-in/one-out; no beat is lost or duplicated.
- Packet mode: ch1 PKT_MODE=1, a 4-beat packet is written with a gap before tlast -> m_tvalid[1] stays 0 until the cycle after tlast is accepted. Then 4 beats emerge, tlast on the 4th, pkt_count 1->0.
- Oversize packet: packet mode, 20-beat packet, DEPTH=16 -> cut_through at count=16. All 20 beats are delivered in order and the next packet is store-and-forward again.
- Async reset: pulse ap_rst_n low mid-packet between clock edges -> m_tvalid and s_tready go to 0 without waiting for a clock edge, count reads 0, and the post-reset first beat is the first output.
